// File: rtl/clk_gate_pkg.sv
// Shared state encoding and sizing helper for the clock-gate sequencer.
package clk_gate_pkg;

  localparam logic [1:0] ST_GATED = 2'd0;
  localparam logic [1:0] ST_WAKE  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_IDLE  = 2'd3;

  // Width of the shared down-counter: it must hold the larger of the two loads.
  function automatic int cnt_width(input int idle, input int wake);
    int m;
    m = (idle > wake) ? idle : wake;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clock_gating_model.sv
// Behavioural clock-gating cell: enable is retimed on the falling edge so
// o_clk only ever produces full-width high pulses.
module clock_gating_model (
  input  logic i_clk,
  input  logic i_clk_en,
  output logic o_clk
);

  logic en_q;

  always_ff @(negedge i_clk) begin
    en_q <= i_clk_en;
  end

  assign o_clk = i_clk & en_q;

endmodule

// File: rtl/clock_gate_controller.sv
// Activity-driven sequencer deciding when the gated clock domain may stop,
// with an idle timeout before gating and a settle period before granting.
//
// state    | meaning
// GATED    | clock stopped, waiting for any request
// WAKE     | enable high, settling before grants
// RUN      | clock running, requesters granted
// IDLE     | no activity seen, counting down to gate
module clock_gate_controller
  import clk_gate_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_force_on,
  output logic [N_REQ-1:0] o_ack,
  output logic             o_clk_en,
  output logic             o_gclk,
  output logic             o_gated,
  output logic [CNT_W-1:0] o_gate_count
);

  localparam int CW = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          any_req;

  assign any_req = (|i_req) | i_force_on;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_GATED;
      cnt          <= '0;
      o_clk_en     <= 1'b0;
      o_gated      <= 1'b1;
      o_gate_count <= '0;
    end else begin
      case (state)
        ST_GATED: begin
          if (any_req) begin
            state    <= ST_WAKE;
            cnt      <= WAKE_LOAD;
            o_clk_en <= 1'b1;
            o_gated  <= 1'b0;
          end
        end
        // Dropped requests do not abort the wake; it always runs to RUN.
        ST_WAKE: begin
          if (cnt == '0) state <= ST_RUN;
          else           cnt   <= cnt - CW'(1);
        end
        ST_RUN: begin
          if (!any_req) begin
            state <= ST_IDLE;
            cnt   <= IDLE_LOAD;
          end
        end
        ST_IDLE: begin
          if (any_req) begin
            state <= ST_RUN;
          end else if (cnt == '0) begin
            state        <= ST_GATED;
            o_clk_en     <= 1'b0;
            o_gated      <= 1'b1;
            o_gate_count <= o_gate_count + CNT_W'(1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_GATED;
      endcase
    end
  end

  // Force-on keeps the clock running but is never granted.
  assign o_ack = i_req & {N_REQ{state == ST_RUN}};

  clock_gating_model u_cg (
    .i_clk    (i_clk),
    .i_clk_en (o_clk_en),
    .o_clk    (o_gclk)
  );

endmodule

// File: tb/tb_clock_gate_controller.sv
// Directed scoreboard bench for clock_gate_controller (N_REQ=2, IDLE=4, WAKE=2, CNT_W=2).
module tb_clock_gate_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic       frc;
  logic [1:0] ack;
  logic       clk_en;
  logic       gclk;
  logic       gated;
  logic [1:0] gate_count;

  always #5 clk = ~clk;

  clock_gate_controller #(
    .N_REQ(2), .IDLE_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .i_force_on   (frc),
    .o_ack        (ack),
    .o_clk_en     (clk_en),
    .o_gclk       (gclk),
    .o_gated      (gated),
    .o_gate_count (gate_count)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic [1:0] ack;
    logic       g;
    logic [1:0] cnt;
    logic       gclk;
    bit         gclk_valid;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] gc = 2'd0;
  logic       prev_en = 1'b0;
  bit         prev_valid = 1'b0;

  // Gated-clock pulse-width monitor: every high pulse must last a full half period.
  time t_rise = 0;
  bit  mon_en = 1'b0;
  int  runts = 0;
  always @(posedge gclk) t_rise = $time;
  always @(negedge gclk) if (mon_en && ($time - t_rise) != 5) runts++;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check them.
  task automatic cyc(input logic r, input logic [1:0] q, input logic f,
                     input logic en, input logic [1:0] a, input logic g);
    exp_t e;
    rst = r; req = q; frc = f;
    e.en = en; e.ack = a; e.g = g; e.cnt = gc;
    e.gclk = prev_en; e.gclk_valid = prev_valid;
    sb.push_back(e);
    prev_en = en; prev_valid = 1'b1;
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("clk_en", {7'd0, clk_en}, {7'd0, e.en});
    chk("ack", {6'd0, ack}, {6'd0, e.ack});
    chk("gated", {7'd0, gated}, {7'd0, e.g});
    chk("gate_count", {6'd0, gate_count}, {6'd0, e.cnt});
    if (e.gclk_valid) chk("gclk", {7'd0, gclk}, {7'd0, e.gclk});
  endtask

  task automatic wake_up(input logic [1:0] q, input logic f);
    cyc(1'b0, q, f, 1'b1, 2'b00, 1'b0);
    cyc(1'b0, q, f, 1'b1, 2'b00, 1'b0);
    cyc(1'b0, q, f, 1'b1, q, 1'b0);
  endtask

  task automatic gate_down();
    repeat (4) cyc(1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
    gc = gc + 2'd1;
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 2'b11; frc = 1'b0;
    #1;
    // Reset held with requests present
    repeat (3) cyc(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b1);
    mon_en = 1'b1;
    wake_up(2'b11, 1'b0);
    gate_down();
    repeat (3) cyc(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);

    // Wake/gate with a 10-cycle request on requester 0
    wake_up(2'b01, 1'b0);
    repeat (7) cyc(1'b0, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0);
    req = 2'b10; #1;
    chk("ack_comb_10", {6'd0, ack}, 8'h02);
    req = 2'b11; #1;
    chk("ack_comb_11", {6'd0, ack}, 8'h03);
    req = 2'b01;
    gate_down();

    // Re-request after two idle edges
    wake_up(2'b01, 1'b0);
    repeat (2) cyc(1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
    repeat (2) cyc(1'b0, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0);
    gate_down();

    // One-cycle pulse while gated: wake still completes, count wraps to 0
    cyc(1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
    gate_down();

    // Force-on for 20 cycles, never acknowledged
    wake_up(2'b00, 1'b1);
    repeat (17) cyc(1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0);
    gate_down();
    chk("wrap_count", {6'd0, gate_count}, 8'h01);

    // Reset mid-IDLE
    wake_up(2'b10, 1'b0);
    repeat (2) cyc(1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
    gc = 2'd0;
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);
    repeat (2) cyc(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);

    // Reset mid-WAKE
    cyc(1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);

    chk("runt_pulses", runts[7:0], 8'd0);
    chk("sb_drained", sb.size() > 0 ? 8'd1 : 8'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
